// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one external ripple-carry adder
// Optional subtract support is compiled in with ADDER_ARB_SUB_EN.
module adder_share_arbiter #(
  parameter int WIDTH = 6,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  input  logic [NREQ-1:0]       cin_bus,
  input  logic [NREQ-1:0]       op_bus,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    g_q, g_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [IW:0]      cand;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin, sel_op;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!pick_found && req[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_op  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_idx == IW'(j)) begin
        sel_a   = a_bus[j*WIDTH +: WIDTH];
        sel_b   = b_bus[j*WIDTH +: WIDTH];
        sel_cin = cin_bus[j];
        sel_op  = op_bus[j];
      end
    end
  end

`ifndef ADDER_ARB_SUB_EN
  logic unused_op;
  assign unused_op = sel_op;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    g_d        = g_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = ISSUE;
          g_d      = pick_idx;
          rr_ptr_d = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);
          add_a_d  = sel_a;
`ifdef ADDER_ARB_SUB_EN
          // Subtract as a + ~b + 1; the client's carry-in is ignored.
          add_b_d   = sel_op ? ~sel_b : sel_b;
          add_cin_d = sel_op ? 1'b1 : sel_cin;
`else
          add_b_d   = sel_b;
          add_cin_d = sel_cin;
`endif
        end
      end
      ISSUE: begin
        state_d    = DONE;
        res_sum_d  = add_sum;
        res_cout_d = add_cout;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      g_q        <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      g_q        <= g_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    busy = (state_q != IDLE);
    if (state_q != IDLE) gnt = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
    if (state_q == DONE) done = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
  end

  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign add_cin  = add_cin_q;
  assign res_sum  = res_sum_q;
  assign res_cout = res_cout_q;

endmodule
